spi_burst_ctrl: RTL and testbench

- Transaction controller directly upstream of the SPI byte-transfer master.
- Accepts a burst command (byte count), streams TX bytes from a valid/ready source into the byte master one at a time, and returns each received byte on a valid/ready RX stream.
- Owns chip-select timing (setup, hold, minimum deselect gap), so software and higher-level blocks handle bursts, not bytes.

---
 rtl/spi_burst_ctrl.sv | 136 +++++++++++++
 tb/tb_spi_burst_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ctrl.sv
// Burst-level SPI transaction controller: sequences chip select and feeds one byte
// at a time to the downstream SPI byte master, returning each received byte.
module spi_burst_ctrl #(
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,

    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,

    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,

    output logic             cs_n,
    output logic             done,

    output logic             spi_start,
    output logic [7:0]       spi_data_in,
    input  logic             spi_busy,
    input  logic [7:0]       spi_data_out
);

    localparam logic [7:0] CNT_SETUP = 8'(CS_SETUP - 1);
    localparam logic [7:0] CNT_HOLD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] CNT_GAP   = 8'(CS_GAP - 1);

    typedef enum logic [3:0] {
        StIdle,
        StSetup,
        StLoad,
        StStart,
        StWaitBusy,
        StWaitDone,
        StPush,
        StHold,
        StGap
    } state_e;

    state_e           state;
    logic [LEN_W-1:0] rem;
    logic [7:0]       cnt;

    // A byte master still busy (e.g. after a reset mid-byte) must finish before a new burst.
    assign cmd_ready = (state == StIdle) && !spi_busy && !rst;
    assign tx_ready  = (state == StLoad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            rem         <= '0;
            cnt         <= '0;
            cs_n        <= 1'b1;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            done        <= 1'b0;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
        end else begin
            done      <= 1'b0;
            spi_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        rem   <= cmd_len;
                        cnt   <= CNT_SETUP;
                        cs_n  <= 1'b0;
                        state <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt == 8'd0) state <= StLoad;
                    else             cnt   <= cnt - 8'd1;
                end
                StLoad: begin
                    if (tx_valid) begin
                        spi_data_in <= tx_data;
                        spi_start   <= 1'b1;
                        state       <= StStart;
                    end
                end
                StStart: begin
                    state <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (spi_busy) state <= StWaitDone;
                end
                StWaitDone: begin
                    if (!spi_busy) begin
                        rx_data  <= spi_data_out;
                        rx_valid <= 1'b1;
                        state    <= StPush;
                    end
                end
                StPush: begin
                    // The next byte waits until the consumer has taken this one.
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        if (rem == '0) begin
                            cnt   <= CNT_HOLD;
                            state <= StHold;
                        end else begin
                            rem   <= rem - LEN_W'(1);
                            state <= StLoad;
                        end
                    end
                end
                StHold: begin
                    if (cnt == 8'd0) begin
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        cnt   <= CNT_GAP;
                        state <= StGap;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StGap: begin
                    if (cnt == 8'd0) state <= StIdle;
                    else             cnt   <= cnt - 8'd1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed self-checking bench for spi_burst_ctrl with a simple SPI byte-master model
// that either loops the sent byte back or returns it inverted.
module tb_spi_burst_ctrl;

    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_GAP   = 4;
    localparam int BT       = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       cs_n;
    logic       done;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic       spi_busy;
    logic [7:0] spi_data_out;

    int         vectors     = 0;
    int         miscompares = 0;
    int         start_cnt   = 0;
    int         done_cnt    = 0;
    bit         mdl_inv     = 1'b0;
    logic [7:0] mdl_b;
    logic [7:0] last_rx;

    spi_burst_ctrl #(
        .LEN_W   (8),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .cs_n        (cs_n),
        .done        (done),
        .spi_start   (spi_start),
        .spi_data_in (spi_data_in),
        .spi_busy    (spi_busy),
        .spi_data_out(spi_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (spi_start === 1'b1) start_cnt <= start_cnt + 1;
        if (done === 1'b1)      done_cnt  <= done_cnt + 1;
    end

    // Byte-master model: busy for BT cycles after a start, then presents the reply.
    initial begin
        spi_busy     = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (spi_start === 1'b1) begin
                mdl_b    = spi_data_in;
                spi_busy = 1'b1;
                repeat (BT) begin
                    @(posedge clk);
                    #1;
                end
                spi_busy     = 1'b0;
                spi_data_out = mdl_inv ? ~mdl_b : mdl_b;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic burst(input int n, input logic [7:0] base, input bit inv, input bit pre_acc,
                         input bit keep_cmd, input int txs_idx, input int txs_len,
                         input int rxs_idx, input int rxs_len);
        int         s0, d0, s1, k, setup_n, hold_n, to_cnt;
        bit         cs_broke, overlap, bad;
        logic [7:0] exp;
        mdl_inv  = inv;
        cs_broke = 1'b0;
        overlap  = 1'b0;
        to_cnt   = 0;
        if (!pre_acc) begin
            k = 0;
            while (!cmd_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("cmd_ready_idle", cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_len   = 8'(n - 1);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        s0 = start_cnt;
        d0 = done_cnt;
        check("cs_fall_after_accept", cs_n, 0);
        setup_n = 0;
        while (!tx_ready && setup_n < 50) begin
            if (cs_n) cs_broke = 1'b1;
            setup_n++;
            @(negedge clk);
        end
        check("cs_setup_cycles", setup_n, CS_SETUP);
        for (int i = 0; i < n; i++) begin
            exp = base + 8'(i);
            if (inv) exp = ~exp;
            if (i == rxs_idx) rx_ready = 1'b0;
            k = 0;
            while (!tx_ready && k < 100) begin
                if (cs_n) cs_broke = 1'b1;
                @(negedge clk);
                k++;
            end
            if (!tx_ready) to_cnt++;
            if (i == txs_idx) begin
                bad = 1'b0;
                repeat (txs_len) begin
                    @(negedge clk);
                    if (!tx_ready || cs_n || spi_start) bad = 1'b1;
                end
                check("tx_starve_hold_load", bad, 0);
            end
            tx_valid = 1'b1;
            tx_data  = base + 8'(i);
            @(negedge clk);
            tx_valid = 1'b0;
            check("spi_start_pulse", spi_start, 1);
            check("spi_data_in", spi_data_in, base + 8'(i));
            k = 0;
            while (!rx_valid && k < 100) begin
                if (tx_ready) overlap = 1'b1;
                if (cs_n) cs_broke = 1'b1;
                @(negedge clk);
                k++;
            end
            if (!rx_valid) to_cnt++;
            if (tx_ready) overlap = 1'b1;
            check("rx_data", rx_data, exp);
            last_rx = rx_data;
            if (i == rxs_idx) begin
                s1  = start_cnt;
                bad = 1'b0;
                repeat (rxs_len) begin
                    @(negedge clk);
                    if (!rx_valid || rx_data !== exp || cs_n || tx_ready) bad = 1'b1;
                end
                check("rx_backpressure_stable", bad, 0);
                check("rx_backpressure_no_start", start_cnt, s1);
                rx_ready = 1'b1;
            end
            @(negedge clk);
            check("rx_valid_drop", rx_valid, 0);
        end
        hold_n = 0;
        while (!cs_n && hold_n < 50) begin
            hold_n++;
            @(negedge clk);
        end
        check("cs_hold_cycles", hold_n, CS_HOLD);
        check("done_pulse", done, 1);
        if (keep_cmd) begin
            cmd_valid = 1'b1;
            cmd_len   = 8'h00;
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("start_count", start_cnt - s0, n);
        check("done_count", done_cnt - d0, 1);
        check("cs_continuous", cs_broke, 0);
        check("no_tx_rx_overlap", overlap, 0);
        check("wait_timeouts", to_cnt, 0);
    endtask

    initial begin
        int k, d0, n_hi, n_rdy, busy_seen, to_cnt;
        bit bad;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = 8'h00;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_done", done, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_spi_data_in", spi_data_in, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // single byte, loopback
        burst(1, 8'hA5, 1'b0, 1'b0, 1'b0, -1, 0, -1, 0);
        check("burst1_rx", last_rx, 8'hA5);

        // four bytes, inverted reply: FE FD FC FB
        burst(4, 8'h01, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0);
        check("burst4_last_rx", last_rx, 8'hFB);

        // RX back-pressure on byte 1 of 2
        burst(2, 8'h30, 1'b0, 1'b0, 1'b0, -1, 0, 0, 20);

        // TX starvation before byte 2 of 3
        burst(3, 8'h40, 1'b0, 1'b0, 1'b0, 1, 15, -1, 0);

        // back-to-back commands with cmd_valid held through the gap
        burst(1, 8'h77, 1'b0, 1'b0, 1'b1, -1, 0, -1, 0);
        n_hi  = 1;
        n_rdy = 0;
        k     = 0;
        while (cs_n && k < 50) begin
            if (cmd_ready) n_rdy++;
            n_hi++;
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        check("gap_cs_high_cycles", n_hi, CS_GAP + 1);
        check("gap_cmd_ready_cycles", n_rdy, 1);
        burst(1, 8'h88, 1'b0, 1'b1, 1'b0, -1, 0, -1, 0);

        // maximum length: 256 bytes, rem must count all the way down
        burst(256, 8'h00, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0);
        check("burst256_last_rx", last_rx, 8'h00);

        // reset during byte 2 of 3
        mdl_inv = 1'b0;
        to_cnt  = 0;
        k = 0;
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        if (!cmd_ready) to_cnt++;
        cmd_valid = 1'b1;
        cmd_len   = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!tx_ready && k < 100) begin @(negedge clk); k++; end
        if (!tx_ready) to_cnt++;
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (!rx_valid && k < 100) begin @(negedge clk); k++; end
        if (!rx_valid) to_cnt++;
        @(negedge clk);
        k = 0;
        while (!tx_ready && k < 100) begin @(negedge clk); k++; end
        if (!tx_ready) to_cnt++;
        tx_valid = 1'b1;
        tx_data  = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (!spi_busy && k < 100) begin @(negedge clk); k++; end
        if (!spi_busy) to_cnt++;
        @(negedge clk);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_tx_ready", tx_ready, 0);
        check("midrst_cmd_ready_busy", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_len   = 8'h00;
        busy_seen = 0;
        bad       = 1'b0;
        k         = 0;
        while (cs_n && k < 100) begin
            if (spi_busy) begin
                busy_seen++;
                if (cmd_ready) bad = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        check("midrst_busy_blocks_cmd", bad, 0);
        check("midrst_busy_seen", busy_seen > 0, 1);
        check("midrst_accept_after_busy", cs_n, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_wait_timeouts", to_cnt, 0);
        burst(1, 8'h5A, 1'b0, 1'b1, 1'b0, -1, 0, -1, 0);
        check("post_rst_rx", last_rx, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
